// File: rtl/uart_tx_if.sv
// Handshake and serial-line signals of the UART transmitter.
// master drives the request and tick side; slave is the transmitter itself.
interface uart_tx_if #(
  parameter int NB_DATA = 8
) ();
  logic               i_tick;
  logic               i_start;
  logic [NB_DATA-1:0] i_data;
  logic               o_tx;
  logic               o_txdone;
  logic               o_busy;

  modport master (
    output i_tick, i_start, i_data,
    input  o_tx, o_txdone, o_busy
  );

  modport slave (
    input  i_tick, i_start, i_data,
    output o_tx, o_txdone, o_busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 16x oversampled tick, LSB first, registered line output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
  parameter int NB_DATA = 8,
  parameter int NB_STOP = 16
) (
  input  logic      clk,
  input  logic      i_rst_n,
  uart_tx_if.slave  bus
);

  localparam logic [3:0] BIT_LAST  = 4'(NB_DATA - 1);
  localparam logic [3:0] STOP_LAST = 4'(NB_STOP - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  state_t             state, state_nxt;
  logic [3:0]         tick_cnt, tick_nxt;
  logic [3:0]         bit_cnt, bit_nxt;
  logic [NB_DATA-1:0] sh, sh_nxt;
  logic               tx, tx_nxt;
  logic               done, done_nxt;
`ifdef UART_TX_PARITY_EN
  logic               par, par_nxt;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      sh       <= sh_nxt;
      tx       <= tx_nxt;
      done     <= done_nxt;
`ifdef UART_TX_PARITY_EN
      par      <= par_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = sh;
    done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          sh_nxt    = bus.i_data;
          tick_nxt  = '0;
          state_nxt = START;
`ifdef UART_TX_PARITY_EN
          par_nxt   = ^bus.i_data;
`endif
        end
      end
      START: begin
        if (bus.i_tick) begin
          if (tick_cnt == 4'd15) begin
            tick_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = DATA;
          end else begin
            tick_nxt = tick_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (bus.i_tick) begin
          if (tick_cnt == 4'd15) begin
            tick_nxt = '0;
            sh_nxt   = sh >> 1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              bit_nxt = bit_cnt + 4'd1;
            end
          end else begin
            tick_nxt = tick_cnt + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bus.i_tick) begin
          if (tick_cnt == 4'd15) begin
            tick_nxt  = '0;
            state_nxt = STOP;
          end else begin
            tick_nxt = tick_cnt + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (bus.i_tick) begin
          if (tick_cnt == STOP_LAST) begin
            tick_nxt  = '0;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            tick_nxt = tick_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tick_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase

    // Line level follows the state being entered so o_tx changes on the same edge.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = sh_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nxt = par_nxt;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  assign bus.o_tx     = tx;
  assign bus.o_txdone = done;
  assign bus.o_busy   = (state != IDLE);

endmodule
